// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the fully-connected layer datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    // Smallest accumulator that can hold n_in full-scale signed products without wrapping.
    function automatic int min_acc_w(input int n_in, input int data_w);
        return 2 * data_w + $clog2(n_in);
    endfunction

    // Arithmetic shift, then clamp into [0, 2^data_w-1]; caller truncates to data_w bits.
    function automatic logic [31:0] relu_sat(input logic signed [63:0] acc,
                                             input int frac_shift,
                                             input int data_w);
        logic signed [63:0] shifted;
        logic signed [63:0] max_val;
        shifted = acc >>> frac_shift;
        max_val = (64'sd1 <<< data_w) - 64'sd1;
        if (shifted < 64'sd0) begin
            return 32'd0;
        end
        if (shifted > max_val) begin
            return max_val[31:0];
        end
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate with synchronous clear, enable and global clock enable.
// Latency: product lands in the accumulator one cycle after en; acc_next shows it combinationally.
// Backpressure: none; holds whenever clk_en is low.
module nn_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     clear,
    input  logic                     en,
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    output logic signed [ACC_W-1:0]  acc_next
);

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        prod  = $signed(a) * $signed(b);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    assign acc_next = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clk_en) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks every neuron/input pair of one FC layer, drives memory reads and the MAC, emits ReLU results.
// Latency: N_IN+3 cycles per neuron with out_ready high; done N_OUT*(N_IN+3)+1 cycles after start.
// Backpressure: result held in WRITE until out_valid&&out_ready; no reads issued while stalled.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_IN       = 16,
    parameter int N_OUT      = 8,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int FRAC_SHIFT = 4,
    localparam int IAW = $clog2(N_IN),
    localparam int WAW = $clog2(N_IN * N_OUT),
    localparam int OIW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IAW-1:0]    in_addr,
    output logic [WAW-1:0]    w_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OIW-1:0]    out_idx,
    output logic [DATA_W-1:0] out_data
);

    localparam int ACC_W_MIN = min_acc_w(N_IN, DATA_W);

    if (ACC_W < ACC_W_MIN) begin : g_acc_w_check
        $error("nn_layer_sequencer: ACC_W too small for N_IN and DATA_W");
    end

    state_e              state_q, state_d;
    logic [IAW-1:0]      i_q, i_d;
    logic [OIW-1:0]      j_q, j_d;
    logic [WAW-1:0]      w_addr_q, w_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_en_q, rd_en_d;
    logic                acc_en_q, acc_en_d;
    logic                out_valid_q, out_valid_d;
    logic [OIW-1:0]      out_idx_q, out_idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic signed [ACC_W-1:0] acc_next;

    nn_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .clear    (state_q == CLEAR),
        .en       (acc_en_q),
        .a        (in_data),
        .b        (w_data),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        w_addr_d    = w_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = rd_en_q;
        acc_en_d    = rd_en_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    j_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                state_d  = FETCH;
                i_d      = '0;
                rd_en_d  = 1'b1;
                w_addr_d = WAW'(int'(j_q) * N_IN);
            end
            FETCH: begin
                if (i_q == IAW'(N_IN - 1)) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    i_d      = i_q + IAW'(1);
                    w_addr_d = w_addr_q + WAW'(1);
                end
            end
            DRAIN: begin
                // acc_next already includes the last product arriving this cycle.
                state_d     = WRITE;
                out_valid_d = 1'b1;
                out_idx_d   = j_q;
                out_data_d  = DATA_W'(relu_sat(64'(acc_next), FRAC_SHIFT, DATA_W));
            end
            WRITE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (j_q == OIW'(N_OUT - 1)) begin
                        state_d = DONE;
                    end else begin
                        j_d     = j_q + OIW'(1);
                        state_d = CLEAR;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            w_addr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else if (clk_en) begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            w_addr_q    <= w_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            acc_en_q    <= acc_en_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign in_addr   = i_q;
    assign w_addr    = w_addr_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer (N_IN=4, N_OUT=2) against a dot-product/ReLU model.
module tb_nn_layer_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int FRAC  = 4;

    localparam int MODE_PLAIN = 0;
    localparam int MODE_CLKEN = 1;
    localparam int MODE_BP    = 2;
    localparam int MODE_RAND  = 3;
    localparam int MODE_BUSY  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic       busy, done, rd_en, out_valid;
    logic [1:0] in_addr;
    logic [2:0] w_addr;
    logic [7:0] in_data = 8'd0;
    logic [7:0] w_data = 8'd0;
    logic [0:0] out_idx;
    logic [7:0] out_data;

    logic signed [7:0] in_mem [N_IN];
    logic signed [7:0] w_mem  [N_IN*N_OUT];

    logic [7:0] got_idx [$];
    logic [7:0] got_dat [$];

    int n_cmp = 0;
    int n_err = 0;

    nn_layer_sequencer #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .DATA_W     (8),
        .ACC_W      (24),
        .FRAC_SHIFT (FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .in_addr   (in_addr),
        .w_addr    (w_addr),
        .in_data   (in_data),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories sharing the DUT clock enable.
    always @(posedge clk) begin
        if (clk_en && rd_en) begin
            in_data <= in_mem[in_addr];
            w_data  <= w_mem[w_addr];
        end
    end

    always @(negedge clk) begin
        if (rst_n && clk_en && out_valid && out_ready) begin
            got_idx.push_back({7'd0, out_idx});
            got_dat.push_back(out_data);
        end
    end

    function automatic logic [7:0] model_out(input int j);
        int s;
        s = 0;
        for (int i = 0; i < N_IN; i++) begin
            s += int'(in_mem[i]) * int'(w_mem[j*N_IN + i]);
        end
        s = s >>> FRAC;
        if (s < 0) s = 0;
        else if (s > 255) s = 255;
        return 8'(s);
    endfunction

    task automatic load(input int in_v, input int w0, input int w1);
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i]        = 8'(in_v);
            w_mem[i]         = 8'(w0);
            w_mem[N_IN + i]  = 8'(w1);
        end
    endtask

    task automatic run_layer(input string name, input int mode, input int exp_cycles);
        int m;
        bit seen;
        int busy_bad;
        int bp_bad;
        logic [0:0] hold_idx;
        logic [7:0] hold_dat;
        got_idx.delete();
        got_dat.delete();
        busy_bad = 0;
        bp_bad = 0;
        hold_idx = '0;
        hold_dat = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        m = 0;
        seen = 1'b0;
        while (!seen && m < 400) begin
            case (mode)
                MODE_CLKEN: clk_en = !(m >= 2 && m <= 4);
                MODE_BP:    out_ready = !(m >= 5 && m <= 10);
                MODE_RAND:  out_ready = 1'($urandom_range(0, 1));
                MODE_BUSY:  start = (m == 5);
                default: ;
            endcase
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (mode == MODE_BP && m == 6) begin
                    hold_idx = out_idx;
                    hold_dat = out_data;
                end
                if (mode == MODE_BP && m >= 6 && m <= 11) begin
                    if (out_valid !== 1'b1 || out_idx !== hold_idx ||
                        out_data !== hold_dat || rd_en !== 1'b0) bp_bad++;
                end
                @(posedge clk); #1;
                m++;
            end
        end
        clk_en = 1'b1;
        out_ready = 1'b1;
        start = 1'b0;

        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s done_timeout: got no done after %0d cycles, expected done", name, m);
        end
        if (exp_cycles > 0) begin
            n_cmp++;
            if (m !== exp_cycles) begin
                n_err++;
                $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, m, exp_cycles);
            end
        end
        n_cmp++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_window: got %0d low cycles and busy=%b at done, expected 0 and 0",
                     name, busy_bad, busy);
        end
        if (mode == MODE_BP) begin
            n_cmp++;
            if (bp_bad != 0) begin
                n_err++;
                $display("FAIL %s backpressure_hold: got %0d unstable cycles, expected 0", name, bp_bad);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: got done=%b busy=%b, expected 0 0", name, done, busy);
        end
        n_cmp++;
        if (got_dat.size() != N_OUT) begin
            n_err++;
            $display("FAIL %s result_count: got %0d, expected %0d", name, got_dat.size(), N_OUT);
        end
        for (int k = 0; k < N_OUT && k < got_dat.size(); k++) begin
            n_cmp++;
            if (got_idx[k] !== 8'(k) || got_dat[k] !== model_out(k)) begin
                n_err++;
                $display("FAIL %s result[%0d]: got idx=%0d data=%0d, expected idx=%0d data=%0d",
                         name, k, got_idx[k], got_dat[k], k, model_out(k));
            end
        end
    endtask

    task automatic check_pair(input string name, input logic [7:0] e0, input logic [7:0] e1);
        n_cmp++;
        if (got_dat.size() != 2 || got_dat[0] !== e0 || got_dat[1] !== e1) begin
            n_err++;
            $display("FAIL %s literal_values: got %0d results, expected %0d then %0d",
                     name, got_dat.size(), e0, e1);
            if (got_dat.size() == 2)
                $display("FAIL %s literal_detail: got %0d then %0d", name, got_dat[0], got_dat[1]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({busy, done, rd_en, out_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy/done/rd_en/out_valid=%b, expected 0000",
                     {busy, done, rd_en, out_valid});
        end
        n_cmp++;
        if (in_addr !== 2'd0 || w_addr !== 3'd0 || out_idx !== 1'b0 || out_data !== 8'd0) begin
            n_err++;
            $display("FAIL reset_data: got in_addr=%0d w_addr=%0d idx=%0d data=%0d, expected all 0",
                     in_addr, w_addr, out_idx, out_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        load(16, 16, 16);
        run_layer("basic", MODE_PLAIN, 15);
        check_pair("basic", 8'd64, 8'd64);
    endtask

    task automatic test_relu;
        load(16, -16, 16);
        run_layer("relu", MODE_PLAIN, 15);
        check_pair("relu", 8'd0, 8'd64);
    endtask

    task automatic test_saturation;
        load(127, 127, 127);
        run_layer("saturation", MODE_PLAIN, 15);
        check_pair("saturation", 8'd255, 8'd255);
    endtask

    task automatic test_backpressure;
        load(16, 16, 16);
        run_layer("backpressure", MODE_BP, 20);
        check_pair("backpressure", 8'd64, 8'd64);
    endtask

    task automatic test_clk_en;
        load(16, 16, 16);
        run_layer("clk_en", MODE_CLKEN, 18);
        check_pair("clk_en", 8'd64, 8'd64);
    endtask

    task automatic test_reset_mid_op;
        load(16, 16, 16);
        got_idx.delete();
        got_dat.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, rd_en, out_valid} !== 4'b0 || in_addr !== 2'd0 || w_addr !== 3'd0 ||
            out_idx !== 1'b0 || out_data !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_op: got ctrl=%b in_addr=%0d w_addr=%0d idx=%0d data=%0d, expected all 0",
                     {busy, done, rd_en, out_valid}, in_addr, w_addr, out_idx, out_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        n_cmp++;
        if (got_dat.size() != 0) begin
            n_err++;
            $display("FAIL reset_partial: got %0d results, expected 0", got_dat.size());
        end
        run_layer("after_reset", MODE_PLAIN, 15);
        check_pair("after_reset", 8'd64, 8'd64);
    endtask

    task automatic test_start_while_busy;
        int busy_seen;
        load(16, 16, 16);
        run_layer("start_busy", MODE_BUSY, 15);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || rd_en !== 1'b0) busy_seen++;
        end
        n_cmp++;
        if (busy_seen != 0 || got_dat.size() != N_OUT) begin
            n_err++;
            $display("FAIL start_busy_ignored: got %0d active cycles and %0d results, expected 0 and %0d",
                     busy_seen, got_dat.size(), N_OUT);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N_IN; i++) begin
                in_mem[i] = (it % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 32)) - 8'd16;
            end
            for (int i = 0; i < N_IN*N_OUT; i++) begin
                w_mem[i] = (it % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 32)) - 8'd16;
            end
            run_layer($sformatf("random%0d", it), MODE_RAND, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_backpressure();
        test_clk_en();
        test_reset_mid_op();
        test_start_while_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
Controller for one fully-connected layer of the neural network datapath. On a start pulse it walks every neuron and every input. For each pair it issues synchronous reads to the input buffer and the weight memory, and drives a signed multiply-accumulate. After the last input of a neuron it applies shift, ReLU and saturation, then hands the result downstream over a valid/ready interface. It sits between the top-level neural_network control and the layer memories and MAC.

Parameters:
N_IN, 16, inputs per neuron (>=2)
N_OUT, 8, neurons in the layer (>=1)
DATA_W, 8, width of input/weight samples (signed) and output (unsigned)
ACC_W, 24, accumulator width; must be >= 2*DATA_W + clog2(N_IN)
FRAC_SHIFT, 4, arithmetic right shift applied to the accumulator before activation

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous and active-low
clk_en  in  1  global clock enable; when low, all registers hold
start  in  1  single-cycle request to process one layer
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the last neuron result is accepted
rd_en  out  1  read strobe to input buffer and weight memory
in_addr  out  clog2(N_IN)  input buffer address i
w_addr  out  clog2(N_IN*N_OUT)  weight address j*N_IN+i
in_data  in  DATA_W  signed input sample; valid the cycle after rd_en
w_data  in  DATA_W  signed weight; valid the cycle after rd_en
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_idx  out  clog2(N_OUT)  neuron index j of out_data
out_data  out  DATA_W  activated neuron output, unsigned

Behaviour:
- Reset: state IDLE. busy, done, rd_en, out_valid = 0. Addresses, out_idx, out_data and accumulator = 0.
- clk_en=0: state, counters, accumulator and outputs hold. The memories share clk_en, so in_data and w_data remain aligned.
- IDLE: start=1 -> CLEAR, j=0, busy=1. start while busy is ignored.
- CLEAR (1 cycle): acc=0, i=0 -> FETCH.
- FETCH (N_IN cycles): rd_en=1, in_addr=i, w_addr=j*N_IN+i, i++.
  - Accumulate on the cycle after each rd_en (1-cycle read latency): acc += sign-extended in_data*w_data.
  - After i=N_IN-1 -> DRAIN.
- DRAIN (1 cycle): rd_en=0; the final product is accumulated -> WRITE.
- WRITE: out_valid=1 and out_idx=j.
  - out_data = relu_sat(acc >>> FRAC_SHIFT): a negative result gives 0, and a result above 2^DATA_W-1 gives 2^DATA_W-1.
  - out_valid, out_idx and out_data stay stable until out_valid&&out_ready.
  - On handshake: if j==N_OUT-1 -> DONE, else j++ and -> CLEAR.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Timing: each neuron takes N_IN+3 cycles with out_ready=1. done rises N_OUT*(N_IN+3)+1 cycles after start is sampled.
- The accumulator never wraps, given the ACC_W rule.
- Asynchronous reset mid-operation: immediate return to IDLE with the reset values above. No partial result is emitted.

Decomposition:
- Package nn_pkg: state enum (IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE), relu_sat function parameterised by DATA_W/ACC_W/FRAC_SHIFT, and a width-check localparam.
- One sub-module, nn_mac_unit: signed multiplier plus ACC_W accumulator with clear, enable and clk_en inputs.
- The sequencer module owns the FSM, the counters i/j, address generation and the output register.

Test Plan:
All scenarios use N_IN=4, N_OUT=2, DATA_W=8, ACC_W=24, FRAC_SHIFT=4, out_ready=1 unless stated.
1. Basic: all inputs 16, all weights 16. Pulse start -> two results, out_idx 0 then 1, both out_data=64. done pulses 15 cycles after start; busy is high across that window.
2. ReLU: neuron 0 weights all -16, neuron 1 weights all 16, inputs 16 -> out_data 0 then 64.
3. Saturation: inputs 127, weights 127 (acc=64516, shifted 4032) -> out_data=255 for both neurons.
4. Backpressure and clk_en:
   - Hold out_ready=0 for 5 cycles in WRITE -> out_valid, out_idx and out_data stable; no new rd_en.
   - Drop clk_en for 3 cycles mid-FETCH -> identical results to scenario 1.
5. Reset and start abuse:
   - Assert rst_n=0 during the second FETCH cycle -> all outputs 0 immediately.
   - A new start after release gives scenario 1 results.
   - A start pulsed while busy has no effect.
